mem_stage: RTL and testbench

//  Y86-64 pipeline memory stage, directly upstream of data_mem. Holds the M pipeline register
//  (loaded from execute), drives data_mem's read/write/address/data, merges valM and

---
 rtl/y86_pkg.sv | 63 ++++++
 rtl/y86_pipe_reg.sv | 45 ++++
 rtl/mem_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 memory stage.
// Contents: instruction codes, status codes, the "no register" id, the
// packed M and W pipeline records with their bubble values, and a helper
// that classifies a status as exceptional.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_reg_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } w_reg_t;

    localparam m_reg_t M_BUBBLE = '{stat: STAT_BUB, icode: ICODE_NOP, cnd: 1'b0,
                                    valE: 64'd0, valA: 64'd0, dstE: RNONE, dstM: RNONE};

    localparam w_reg_t W_BUBBLE = '{stat: STAT_BUB, icode: ICODE_NOP,
                                    valE: 64'd0, valM: 64'd0, dstE: RNONE, dstM: RNONE};

    // A bubble is never exceptional; only HLT, ADR and INS stop the machine.
    function automatic logic is_exception(input logic [2:0] stat);
        logic exc;
        case (stat)
            STAT_HLT, STAT_ADR, STAT_INS: exc = 1'b1;
            default:                      exc = 1'b0;
        endcase
        return exc;
    endfunction

endpackage

// File: rtl/y86_pipe_reg.sv
// Generic pipeline register with hold / bubble / load control.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (resets to BUBBLE_VAL)
//   hold_i      keep current contents (highest priority)
//   bubble_i    load BUBBLE_VAL
//   d_i         normal load data
//   q_o         register contents
module y86_pipe_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             bubble_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state selection: hold beats bubble beats load.
    always_comb begin
        if (hold_i) begin
            q_d = q_q;
        end else if (bubble_i) begin
            q_d = BUBBLE_VAL;
        end else begin
            q_d = d_i;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= BUBBLE_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: M pipeline register, data-memory control, status
// merge, W pipeline register and the sticky halt flag.
// Ports:
//   e_*            execute-stage results loaded into M
//   M_bubble       load a bubble into M; W_stall holds both M and W
//   mem_read/mem_write/mem_addr/mem_data  drive data_mem
//   valM, dmem_error                      returned by data_mem (combinational)
//   M_*            M register contents (forwarding)
//   m_stat         status of the instruction currently in M
//   W_*            W register contents (write-back)
//   halted         sticky: an exceptional instruction has reached W
module mem_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic        e_cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    input  logic        M_bubble,
    input  logic        W_stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_data,
    input  logic [63:0] valM,
    input  logic        dmem_error,
    output logic [3:0]  M_icode,
    output logic        M_cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [2:0]  m_stat,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic        halted
);

    // Highest legal 8-byte access address.
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES - 8);

    m_reg_t      m_d;
    m_reg_t      m_q;
    w_reg_t      w_d;
    w_reg_t      w_q;
    logic        halted_q;
    logic        halted_d;
    logic        freeze_s;
    logic        rd_op_s;
    logic        wr_op_s;
    logic [63:0] addr_s;
    logic        addr_err_s;
    logic [2:0]  m_stat_s;
    logic        mem_read_s;
    logic        mem_write_s;

    // Once halted, and while write-back is stalled, both registers hold.
    assign freeze_s = halted_q | W_stall;

    // M register input record from execute.
    always_comb begin
        m_d.stat  = e_stat;
        m_d.icode = e_icode;
        m_d.cnd   = e_cnd;
        m_d.valE  = e_valE;
        m_d.valA  = e_valA;
        m_d.dstE  = e_dstE;
        m_d.dstM  = e_dstM;
    end

    y86_pipe_reg #(
        .WIDTH      ($bits(m_reg_t)),
        .BUBBLE_VAL (M_BUBBLE)
    ) u_m_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (freeze_s),
        .bubble_i (M_bubble),
        .d_i      (m_d),
        .q_o      (m_q)
    );

    // Decode the memory operation and address source from the M icode.
    always_comb begin
        rd_op_s = 1'b0;
        wr_op_s = 1'b0;
        addr_s  = 64'd0;
        case (m_q.icode)
            ICODE_RMMOVQ, ICODE_PUSHQ, ICODE_CALL: begin
                wr_op_s = 1'b1;
                addr_s  = m_q.valE;
            end
            ICODE_MRMOVQ: begin
                rd_op_s = 1'b1;
                addr_s  = m_q.valE;
            end
            ICODE_POPQ, ICODE_RET: begin
                rd_op_s = 1'b1;
                addr_s  = m_q.valA;
            end
            default: begin
                rd_op_s = 1'b0;
                wr_op_s = 1'b0;
                addr_s  = 64'd0;
            end
        endcase
    end

    assign addr_err_s = (rd_op_s | wr_op_s) & (dmem_error | (addr_s > ADDR_LIMIT));

    // An address fault only overrides a healthy status; earlier faults win.
    always_comb begin
        if (addr_err_s && (m_q.stat == STAT_AOK)) begin
            m_stat_s = STAT_ADR;
        end else begin
            m_stat_s = m_q.stat;
        end
    end

    assign mem_read_s  = rd_op_s & (m_q.stat == STAT_AOK) & ~addr_err_s & ~halted_q;
    // Gating with W_stall commits the store exactly once, on the edge M advances.
    assign mem_write_s = wr_op_s & (m_q.stat == STAT_AOK) & ~addr_err_s & ~halted_q & ~W_stall;

    // W register input record; valM is only meaningful for an actual read.
    always_comb begin
        w_d.stat  = m_stat_s;
        w_d.icode = m_q.icode;
        w_d.valE  = m_q.valE;
        if (mem_read_s) begin
            w_d.valM = valM;
        end else begin
            w_d.valM = 64'd0;
        end
        w_d.dstE  = m_q.dstE;
        w_d.dstM  = m_q.dstM;
    end

    y86_pipe_reg #(
        .WIDTH      ($bits(w_reg_t)),
        .BUBBLE_VAL (W_BUBBLE)
    ) u_w_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (freeze_s),
        .bubble_i (1'b0),
        .d_i      (w_d),
        .q_o      (w_q)
    );

    // Halt becomes set on the edge W accepts an exceptional status.
    always_comb begin
        if (!freeze_s && is_exception(m_stat_s)) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end
    end

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign mem_read  = mem_read_s;
    assign mem_write = mem_write_s;
    assign mem_addr  = addr_s;
    assign mem_data  = m_q.valA;
    assign m_stat    = m_stat_s;

    assign M_icode = m_q.icode;
    assign M_cnd   = m_q.cnd;
    assign M_valE  = m_q.valE;
    assign M_valA  = m_q.valA;
    assign M_dstE  = m_q.dstE;
    assign M_dstM  = m_q.dstM;

    assign W_stat  = w_q.stat;
    assign W_icode = w_q.icode;
    assign W_valE  = w_q.valE;
    assign W_valM  = w_q.valM;
    assign W_dstE  = w_q.dstE;
    assign W_dstM  = w_q.dstM;

    assign halted = halted_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios followed by random traffic.
// A transaction-level model predicts the visible state after each cycle and
// queues it; a monitor on the falling edge pops and compares.
module tb_mem_stage;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        M_bubble;
    logic        W_stall;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic [63:0] valM;
    logic        dmem_error;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic        halted;

    always #5 clk = ~clk;

    mem_stage #(.MEM_BYTES(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd), .e_valE(e_valE),
        .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .M_bubble(M_bubble), .W_stall(W_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .valM(valM), .dmem_error(dmem_error),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .m_stat(m_stat),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .halted(halted)
    );

    // data_mem stand-in: 32 words, faults on misaligned addresses.
    logic [63:0] dmem [0:31];
    assign valM       = (mem_addr < 64'd256) ? dmem[mem_addr[7:3]] : 64'd0;
    assign dmem_error = (mem_addr[2:0] != 3'd0);
    always @(posedge clk) begin
        if (mem_write && (mem_addr < 64'd256)) dmem[mem_addr[7:3]] <= mem_data;
    end

    typedef struct packed {
        logic [2:0] stat; logic [3:0] icode; logic cnd;
        logic [63:0] valE; logic [63:0] valA; logic [3:0] dstE; logic [3:0] dstM;
        logic bub; logic stall;
    } stim_t;
    typedef struct packed {
        logic [2:0] stat; logic [3:0] icode; logic cnd;
        logic [63:0] valE; logic [63:0] valA; logic [3:0] dstE; logic [3:0] dstM;
    } inst_t;
    typedef struct packed {
        logic [2:0] stat; logic [3:0] icode;
        logic [63:0] valE; logic [63:0] valM; logic [3:0] dstE; logic [3:0] dstM;
    } wres_t;
    typedef struct packed {
        wres_t w; inst_t m; logic halted; logic rd; logic wr;
        logic [63:0] addr; logic [2:0] mstat;
    } snap_t;

    // Reference model state
    inst_t       ref_m;
    wres_t       ref_w;
    logic        ref_halted;
    logic [63:0] ref_mem [0:31];
    stim_t       cur;
    snap_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_push = 0;
    int          n_pop  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural meaning of the instruction in M: which access, where, resulting status.
    function automatic void access(input inst_t m, output bit rd_ok, output bit wr_ok,
                                   output logic [63:0] a, output logic [2:0] st);
        bit rd, wr, bad;
        rd  = m.icode inside {ICODE_MRMOVQ, ICODE_POPQ, ICODE_RET};
        wr  = m.icode inside {ICODE_RMMOVQ, ICODE_PUSHQ, ICODE_CALL};
        if (m.icode inside {ICODE_POPQ, ICODE_RET}) a = m.valA;
        else if (rd || wr)                          a = m.valE;
        else                                        a = 64'd0;
        bad   = (rd || wr) && ((a[2:0] != 3'd0) || (a > 64'd248));
        st    = (bad && m.stat == STAT_AOK) ? STAT_ADR : m.stat;
        rd_ok = rd && !bad && (m.stat == STAT_AOK);
        wr_ok = wr && !bad && (m.stat == STAT_AOK);
    endfunction

    task automatic model_reset();
        ref_m = '{stat: STAT_BUB, icode: ICODE_NOP, cnd: 1'b0, valE: 64'd0, valA: 64'd0,
                  dstE: 4'hF, dstM: 4'hF};
        ref_w = '{stat: STAT_BUB, icode: ICODE_NOP, valE: 64'd0, valM: 64'd0,
                  dstE: 4'hF, dstM: 4'hF};
        ref_halted = 1'b0;
    endtask

    // One clock edge of the machine at instruction level.
    task automatic model_edge();
        bit rd_ok, wr_ok;
        logic [63:0] a;
        logic [2:0]  st;
        if (!(ref_halted || cur.stall)) begin
            access(ref_m, rd_ok, wr_ok, a, st);
            ref_w.stat  = st;
            ref_w.icode = ref_m.icode;
            ref_w.valE  = ref_m.valE;
            ref_w.valM  = rd_ok ? ref_mem[a[7:3]] : 64'd0;
            ref_w.dstE  = ref_m.dstE;
            ref_w.dstM  = ref_m.dstM;
            if (wr_ok) ref_mem[a[7:3]] = ref_m.valA;
            if (st inside {STAT_HLT, STAT_ADR, STAT_INS}) ref_halted = 1'b1;
            if (cur.bub) begin
                ref_m = '{stat: STAT_BUB, icode: ICODE_NOP, cnd: 1'b0, valE: 64'd0,
                          valA: 64'd0, dstE: 4'hF, dstM: 4'hF};
            end else begin
                ref_m = '{stat: cur.stat, icode: cur.icode, cnd: cur.cnd, valE: cur.valE,
                          valA: cur.valA, dstE: cur.dstE, dstM: cur.dstM};
            end
        end
    endtask

    task automatic push_snap();
        snap_t s;
        bit rd_ok, wr_ok;
        logic [63:0] a;
        logic [2:0]  st;
        access(ref_m, rd_ok, wr_ok, a, st);
        s.w      = ref_w;
        s.m      = ref_m;
        s.halted = ref_halted;
        s.rd     = rd_ok && !ref_halted;
        s.wr     = wr_ok && !ref_halted && !cur.stall;
        s.addr   = a;
        s.mstat  = st;
        exp_q.push_back(s);
        n_push++;
    endtask

    task automatic drive(input stim_t s);
        e_stat = s.stat; e_icode = s.icode; e_cnd = s.cnd; e_valE = s.valE; e_valA = s.valA;
        e_dstE = s.dstE; e_dstM = s.dstM; M_bubble = s.bub; W_stall = s.stall;
    endtask

    task automatic cycle(input stim_t nx, input bit do_rst);
        @(posedge clk);
        #1;
        model_edge();
        if (do_rst) begin
            rst_n = 1'b0;
            model_reset();
        end
        cur = nx;
        drive(cur);
        push_snap();
        if (do_rst) begin
            @(negedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    function automatic stim_t mk(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] ve,
                                 input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                                 input logic bub, input logic stall);
        stim_t s;
        s.stat = st; s.icode = ic; s.cnd = 1'b0; s.valE = ve; s.valA = va;
        s.dstE = de; s.dstM = dm; s.bub = bub; s.stall = stall;
        return s;
    endfunction

    function automatic logic [63:0] rand_addr();
        int k;
        k = $urandom_range(0, 39);
        if (k < 34)       return 64'($urandom_range(0, 31)) << 3;
        else if (k == 34) return 64'd248;
        else if (k == 35) return 64'd249;
        else if (k == 36) return 64'd256;
        else if (k == 37) return {$urandom, $urandom};
        else if (k == 38) return 64'($urandom_range(0, 255));
        else              return 64'hFFFF_FFFF_FFFF_FFF8;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        if ($urandom_range(0, 99) < 4) s.icode = 4'($urandom_range(12, 15));
        else                           s.icode = 4'($urandom_range(0, 11));
        if ($urandom_range(0, 99) < 95) s.stat = STAT_AOK;
        else                            s.stat = 3'($urandom_range(0, 4));
        s.cnd   = 1'($urandom_range(0, 1));
        s.valE  = rand_addr();
        s.valA  = ($urandom_range(0, 1) == 1) ? rand_addr() : {$urandom, $urandom};
        s.dstE  = 4'($urandom_range(0, 15));
        s.dstM  = 4'($urandom_range(0, 15));
        s.bub   = ($urandom_range(0, 99) < 10);
        s.stall = ($urandom_range(0, 99) < 15);
        return s;
    endfunction

    // Monitor: compare every visible output against the queued prediction.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pop++;
                chk("W_stat",    64'(W_stat),    64'(e.w.stat));
                chk("W_icode",   64'(W_icode),   64'(e.w.icode));
                chk("W_valE",    W_valE,         e.w.valE);
                chk("W_valM",    W_valM,         e.w.valM);
                chk("W_dstE",    64'(W_dstE),    64'(e.w.dstE));
                chk("W_dstM",    64'(W_dstM),    64'(e.w.dstM));
                chk("M_icode",   64'(M_icode),   64'(e.m.icode));
                chk("M_cnd",     64'(M_cnd),     64'(e.m.cnd));
                chk("M_valE",    M_valE,         e.m.valE);
                chk("M_valA",    M_valA,         e.m.valA);
                chk("M_dstE",    64'(M_dstE),    64'(e.m.dstE));
                chk("M_dstM",    64'(M_dstM),    64'(e.m.dstM));
                chk("m_stat",    64'(m_stat),    64'(e.mstat));
                chk("halted",    64'(halted),    64'(e.halted));
                chk("mem_read",  64'(mem_read),  64'(e.rd));
                chk("mem_write", 64'(mem_write), 64'(e.wr));
                chk("mem_addr",  mem_addr,       e.addr);
                chk("mem_data",  mem_data,       e.m.valA);
            end
        end
    end

    stim_t idle;

    initial begin
        for (int i = 0; i < 32; i++) begin
            dmem[i]    = 64'd0;
            ref_mem[i] = 64'd0;
        end
        idle  = mk(ICODE_NOP, STAT_AOK, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        cur = idle;
        drive(cur);
        push_snap();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Store then load back through the same address.
        cycle(mk(ICODE_RMMOVQ, STAT_AOK, 64'h10, 64'hDEAD, 4'hF, 4'hF, 1'b0, 1'b0), 1'b0);
        cycle(mk(ICODE_MRMOVQ, STAT_AOK, 64'h10, 64'h0, 4'hF, 4'h3, 1'b0, 1'b0), 1'b0);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);

        // Pop from 0x20 after storing 0x55 there; bubble enters M behind the pop.
        cycle(mk(ICODE_RMMOVQ, STAT_AOK, 64'h20, 64'h55, 4'hF, 4'hF, 1'b0, 1'b0), 1'b0);
        cycle(mk(ICODE_POPQ, STAT_AOK, 64'h28, 64'h20, 4'h4, 4'h5, 1'b0, 1'b0), 1'b0);
        cycle(mk(ICODE_RMMOVQ, STAT_AOK, 64'h40, 64'h99, 4'hF, 4'hF, 1'b1, 1'b0), 1'b0);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);

        // Push held by a three-cycle stall, bubble request ignored while stalled.
        cycle(mk(ICODE_PUSHQ, STAT_AOK, 64'h30, 64'h77, 4'h4, 4'hF, 1'b0, 1'b0), 1'b0);
        cycle(mk(ICODE_MRMOVQ, STAT_AOK, 64'h30, 64'h0, 4'hF, 4'h2, 1'b0, 1'b1), 1'b0);
        cycle(mk(ICODE_MRMOVQ, STAT_AOK, 64'h30, 64'h0, 4'hF, 4'h2, 1'b1, 1'b1), 1'b0);
        cycle(mk(ICODE_MRMOVQ, STAT_AOK, 64'h30, 64'h0, 4'hF, 4'h2, 1'b0, 1'b1), 1'b0);
        cycle(mk(ICODE_MRMOVQ, STAT_AOK, 64'h30, 64'h0, 4'hF, 4'h2, 1'b0, 1'b0), 1'b0);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);

        // Highest legal address, then the first illegal one halts the machine.
        cycle(mk(ICODE_RMMOVQ, STAT_AOK, 64'hF8, 64'hBEEF, 4'hF, 4'hF, 1'b0, 1'b0), 1'b0);
        cycle(mk(ICODE_MRMOVQ, STAT_AOK, 64'hF8, 64'h0, 4'hF, 4'h6, 1'b0, 1'b0), 1'b0);
        cycle(mk(ICODE_MRMOVQ, STAT_AOK, 64'hF9, 64'h0, 4'hF, 4'h7, 1'b0, 1'b0), 1'b0);
        cycle(mk(ICODE_PUSHQ, STAT_AOK, 64'h50, 64'h11, 4'h4, 4'hF, 1'b0, 1'b0), 1'b0);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);

        // HALT reaches W, then a mid-cycle reset.
        cycle(mk(ICODE_HALT, STAT_HLT, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0), 1'b1);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);
        cycle(idle, 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            cycle(rand_stim(), ($urandom_range(0, 99) < 3));
        end
        cycle(idle, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 64'(n_pop), 64'(n_push));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
